// File: rtl/leaf_arb_pkg.sv
// Shared definitions for the leaf output arbiter: FSM encoding, default burst
// length and the rotated-priority search used by rr_pick.
package leaf_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_BURST_LEN = 16;
    localparam int MAX_REQ           = 16;

    // Returns {found, index} of the first set bit of req, scanning from last+1
    // upward and wrapping modulo n. Only the low n bits of req are considered.
    function automatic logic [4:0] rr_search(input logic [MAX_REQ-1:0] req,
                                             input logic [3:0]         last,
                                             input int                 n);
        logic       found;
        logic [3:0] pick;
        int         k;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            k = (int'(last) + i) % n;
            if (i <= n && !found && req[k[3:0]]) begin
                found = 1'b1;
                pick  = k[3:0];
            end
        end
        return {found, pick};
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx, wrapping.
module rr_pick
    import leaf_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_BITS-1:0] last_idx,
    output logic                any,
    output logic [REQ_BITS-1:0] idx
);

    logic [4:0] res;

    assign res = rr_search(MAX_REQ'(req), 4'(last_idx), NUM_REQ);
    assign any = res[4];
    assign idx = res[REQ_BITS-1:0];

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing one leaf_interface output port between NUM_REQ
// vld/ack streams; a grant is held for up to BURST_LEN beats.
module leaf_out_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int REQ_BITS     = 2,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = DEFAULT_BURST_LEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_mask,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_REQ-1:0]              vld_user2arb,
    output logic [NUM_REQ-1:0]              ack_arb2user,
    output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
    output logic                            vld_arb2interface,
    input  logic                            ack_interface2arb,
    output logic [REQ_BITS-1:0]             grant_idx,
    output logic                            grant_active,
    output logic [31:0]                     beat_total
);

    arb_state_e          state_q, state_d;
    logic [REQ_BITS-1:0] grant_q, grant_d;
    logic [REQ_BITS-1:0] last_q, last_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [31:0]         total_q, total_d;

    logic [NUM_REQ-1:0]  cand;
    logic                pick_any;
    logic [REQ_BITS-1:0] pick_idx;
    logic                xfer;

    assign cand = vld_user2arb & req_mask;

    rr_pick #(.NUM_REQ(NUM_REQ), .REQ_BITS(REQ_BITS)) u_pick (
        .req      (cand),
        .last_idx (last_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    assign xfer = (state_q == GRANT) && vld_user2arb[grant_q] && ack_interface2arb;

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        last_d             = last_q;
        beat_cnt_d         = beat_cnt_q;
        total_d            = total_q;
        ack_arb2user       = '0;
        dout_arb2interface = '0;
        vld_arb2interface  = 1'b0;
        grant_active       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                grant_active          = 1'b1;
                dout_arb2interface    = din_user2arb[grant_q*PAYLOAD_BITS +: PAYLOAD_BITS];
                vld_arb2interface     = vld_user2arb[grant_q];
                ack_arb2user[grant_q] = ack_interface2arb;
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    total_d    = total_q + 32'd1;
                    if (beat_cnt_q == 8'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (!vld_user2arb[grant_q]) begin
                    // Stream paused or finished: free the port rather than idle on it.
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= REQ_BITS'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            total_q    <= total_d;
        end
    end

    assign grant_idx  = grant_q;
    assign beat_total = total_q;

endmodule
